// File: rtl/alu_sequencer.sv
// Sequences LOAD/arithmetic/CLR requests through an external 8-bit arithmetic unit into an accumulator.
// Optional build macro ALU_SEQ_SAT_EN: saturate the accumulator on signed overflow.
module alu_sequencer #(
  localparam int unsigned DW  = 8,
  localparam int unsigned OPW = 3,
  localparam int unsigned SW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [OPW-1:0] req_op,
  input  logic [DW-1:0] req_operand,
  output logic [DW-1:0] au_a,
  output logic [DW-1:0] au_b,
  output logic          au_cin,
  output logic [SW-1:0] au_s,
  input  logic [DW-1:0] au_data,
  input  logic          au_cout,
  input  logic          au_ovf,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] acc,
  output logic          carry,
  output logic          ovf,
  output logic          zero
);

  localparam logic [OPW-1:0] OP_LOAD = 3'd0;
  localparam logic [OPW-1:0] OP_ADD  = 3'd1;
  localparam logic [OPW-1:0] OP_ADC  = 3'd2;
  localparam logic [OPW-1:0] OP_SUB  = 3'd3;
  localparam logic [OPW-1:0] OP_SBB  = 3'd4;
  localparam logic [OPW-1:0] OP_INC  = 3'd5;
  localparam logic [OPW-1:0] OP_DEC  = 3'd6;
  localparam logic [OPW-1:0] OP_CLR  = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_next;
  logic [OPW-1:0]  op_q;
  logic [DW-1:0]   opd_q;
  logic [DW-1:0]   acc_next;
  logic            carry_next, ovf_next, zero_next;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Arithmetic unit controls; only meaningful while executing
  always_comb begin
    au_a   = acc;
    au_b   = '0;
    au_s   = 2'd0;
    au_cin = 1'b0;
    if (state == EXEC) begin
      au_b = opd_q;
      case (op_q)
        OP_ADD:  begin au_s = 2'd1; au_cin = 1'b0;  end
        OP_ADC:  begin au_s = 2'd1; au_cin = carry; end
        OP_SUB:  begin au_s = 2'd2; au_cin = 1'b1;  end
        OP_SBB:  begin au_s = 2'd2; au_cin = carry; end
        OP_INC:  begin au_s = 2'd0; au_cin = 1'b1;  end
        OP_DEC:  begin au_s = 2'd3; au_cin = 1'b0;  end
        default: begin au_s = 2'd0; au_cin = 1'b0;  end
      endcase
    end
  end

  // Accumulator/flag result of the op held in op_q
  always_comb begin
    acc_next   = acc;
    carry_next = carry;
    ovf_next   = ovf;
    zero_next  = zero;
    case (op_q)
      OP_LOAD: begin
        acc_next  = opd_q;
        zero_next = (opd_q == '0);
      end
      OP_CLR: begin
        acc_next   = '0;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
        zero_next  = 1'b1;
      end
      default: begin
        carry_next = au_cout;
        ovf_next   = au_ovf;
`ifdef ALU_SEQ_SAT_EN
        if (au_ovf) begin
          acc_next  = acc[DW-1] ? 8'h80 : 8'h7F;
          zero_next = 1'b0;
        end else begin
          acc_next  = au_data;
          zero_next = (au_data == '0);
        end
`else
        acc_next  = au_data;
        zero_next = (au_data == '0);
`endif
      end
    endcase
  end

  // State, handshake outputs and accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      op_q      <= '0;
      opd_q     <= '0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      if (state == IDLE && req_valid) begin
        op_q  <= req_op;
        opd_q <= req_operand;
      end
    end
  end

  // Accumulator and flags update only on the EXEC edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b1;
    end else if (state == EXEC) begin
      acc   <= acc_next;
      carry <= carry_next;
      ovf   <= ovf_next;
      zero  <= zero_next;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scoreboard bench for alu_sequencer with an ideal 8-bit arithmetic unit model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'd0;
  logic [7:0] req_operand = 8'd0;
  logic [7:0] au_a, au_b, au_data;
  logic       au_cin, au_cout, au_ovf;
  logic [1:0] au_s;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] acc;
  logic       carry, ovf, zero;

  int tests = 0;
  int fails = 0;
  bit ovf_force = 1'b0;

`ifdef ALU_SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] acc;
    logic       carry;
    logic       ovf;
    logic       zero;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_acc = 8'h00;
  logic       m_carry = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_zero = 1'b1;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_operand(req_operand),
    .au_a(au_a), .au_b(au_b), .au_cin(au_cin), .au_s(au_s),
    .au_data(au_data), .au_cout(au_cout), .au_ovf(au_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .acc(acc), .carry(carry), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // Ideal AU: s=0 a+cin, s=1 a+b+cin, s=2 a+~b+cin, s=3 a+0xFF+cin
  logic [7:0] bb;
  logic [8:0] sum;
  always_comb begin
    case (au_s)
      2'd0:    bb = 8'h00;
      2'd1:    bb = au_b;
      2'd2:    bb = ~au_b;
      default: bb = 8'hFF;
    endcase
    sum     = {1'b0, au_a} + {1'b0, bb} + {8'b0, au_cin};
    au_data = sum[7:0];
    au_cout = sum[8];
    au_ovf  = ovf_force | ((au_a[7] == bb[7]) && (sum[7] != au_a[7]));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one op on the bench-side accumulator model
  task automatic model_op(input logic [2:0] op, input logic [7:0] opd);
    int a, b, sa, sb_, r, sr, bw;
    bit c, v, arith;
    a = int'(m_acc); b = int'(opd);
    sa = (a >= 128) ? a - 256 : a;
    sb_ = (b >= 128) ? b - 256 : b;
    bw = m_carry ? 0 : 1;
    r = 0; sr = 0; c = 1'b0; arith = 1'b1;
    case (op)
      3'd1: begin r = a + b; c = (r > 255); sr = sa + sb_; end
      3'd2: begin r = a + b + int'(m_carry); c = (r > 255); sr = sa + sb_ + int'(m_carry); end
      3'd3: begin r = a - b; c = (a >= b); sr = sa - sb_; end
      3'd4: begin r = a - b - bw; c = (a >= b + bw); sr = sa - sb_ - bw; end
      3'd5: begin r = a + 1; c = (r > 255); sr = sa + 1; end
      3'd6: begin r = a - 1; c = (a >= 1); sr = sa - 1; end
      default: arith = 1'b0;
    endcase
    if (op == 3'd0) begin
      m_acc = opd; m_zero = (opd == 8'h00);
    end else if (op == 3'd7) begin
      m_acc = 8'h00; m_carry = 1'b0; m_ovf = 1'b0; m_zero = 1'b1;
    end else if (arith) begin
      v = (sr > 127) || (sr < -128) || ovf_force;
      m_carry = c;
      m_ovf = v;
      if (SAT && v) begin
        m_acc = m_acc[7] ? 8'h80 : 8'h7F;
        m_zero = 1'b0;
      end else begin
        m_acc = 8'(r & 255);
        m_zero = (m_acc == 8'h00);
      end
    end
  endtask

  // Issue one request (called at a negedge with the DUT idle) and retire its response
  task automatic do_op(input logic [2:0] op, input logic [7:0] opd, input int hold);
    logic [1:0] e_s;
    logic       e_cin;
    logic [7:0] e_a;
    exp_t       e;
    int         waited;
    e_a = m_acc;
    case (op)
      3'd1: begin e_s = 2'd1; e_cin = 1'b0; end
      3'd2: begin e_s = 2'd1; e_cin = m_carry; end
      3'd3: begin e_s = 2'd2; e_cin = 1'b1; end
      3'd4: begin e_s = 2'd2; e_cin = m_carry; end
      3'd5: begin e_s = 2'd0; e_cin = 1'b1; end
      3'd6: begin e_s = 2'd3; e_cin = 1'b0; end
      default: begin e_s = 2'd0; e_cin = 1'b0; end
    endcase
    check("idle_req_ready", 8'(req_ready), 8'd1);
    req_valid = 1'b1; req_op = op; req_operand = opd;
    model_op(op, opd);
    sb.push_back('{acc: m_acc, carry: m_carry, ovf: m_ovf, zero: m_zero});
    @(negedge clk);
    req_valid = 1'b0; req_op = 3'($urandom); req_operand = 8'($urandom);
    check("exec_req_ready", 8'(req_ready), 8'd0);
    check("exec_rsp_valid", 8'(rsp_valid), 8'd0);
    check("exec_au_s", 8'(au_s), 8'(e_s));
    check("exec_au_cin", 8'(au_cin), 8'(e_cin));
    check("exec_au_a", au_a, e_a);
    check("exec_au_b", au_b, opd);
    @(negedge clk);
    check("rsp_latency", 8'(rsp_valid), 8'd1);
    waited = 0;
    while (rsp_valid !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (rsp_valid !== 1'b1) check("rsp_timeout", 8'(rsp_valid), 8'd1);
    e = sb.pop_front();
    check("rsp_acc", acc, e.acc);
    check("rsp_carry", 8'(carry), 8'(e.carry));
    check("rsp_ovf", 8'(ovf), 8'(e.ovf));
    check("rsp_zero", 8'(zero), 8'(e.zero));
    check("rsp_au_b", au_b, 8'h00);
    for (int i = 0; i < hold; i++) begin
      req_valid = ~req_valid; req_op = 3'($urandom); req_operand = 8'($urandom);
      @(negedge clk);
      check("hold_rsp_valid", 8'(rsp_valid), 8'd1);
      check("hold_acc", acc, e.acc);
      check("hold_req_ready", 8'(req_ready), 8'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("back_idle_ready", 8'(req_ready), 8'd1);
    check("back_idle_rsp", 8'(rsp_valid), 8'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_acc", acc, 8'h00);
    check("rst_zero", 8'(zero), 8'd1);
    check("rst_carry", 8'(carry), 8'd0);
    check("rst_ovf", 8'(ovf), 8'd0);
    check("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 8'(req_ready), 8'd1);
    check("rst_au_s", 8'(au_s), 8'd0);

    do_op(3'd0, 8'h3C, 0);
    do_op(3'd1, 8'h05, 0);
    check("add_acc_41", acc, 8'h41);
    do_op(3'd0, 8'hFF, 0);
    do_op(3'd5, 8'h00, 0);
    check("inc_wrap_acc", acc, 8'h00);
    check("inc_wrap_carry", 8'(carry), 8'd1);
    do_op(3'd2, 8'h00, 0);
    check("adc_acc_01", acc, 8'h01);
    do_op(3'd0, 8'h10, 0);
    do_op(3'd3, 8'h10, 0);
    check("sub_zero", 8'(zero), 8'd1);
    do_op(3'd6, 8'h00, 0);
    check("dec_wrap_acc", acc, 8'hFF);
    check("dec_wrap_carry", 8'(carry), 8'd0);
    do_op(3'd1, 8'h22, 5);
    do_op(3'd4, 8'h30, 0);
    do_op(3'd4, 8'h01, 0);
    do_op(3'd7, 8'h55, 0);
    do_op(3'd0, 8'h00, 0);
    do_op(3'd0, 8'h7F, 0);
    do_op(3'd1, 8'h01, 0);
    do_op(3'd0, 8'h80, 0);
    do_op(3'd6, 8'h00, 0);

    ovf_force = 1'b1;
    do_op(3'd0, 8'h70, 0);
    do_op(3'd1, 8'h01, 0);
    check("forced_ovf_acc", acc, SAT ? 8'h7F : 8'h71);
    ovf_force = 1'b0;

    // Reset during EXEC aborts the op
    do_op(3'd0, 8'h20, 0);
    req_valid = 1'b1; req_op = 3'd1; req_operand = 8'h01;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_acc", acc, 8'h00);
    check("abort_zero", 8'(zero), 8'd1);
    check("abort_rsp_valid", 8'(rsp_valid), 8'd0);
    m_acc = 8'h00; m_carry = 1'b0; m_ovf = 1'b0; m_zero = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 8'(rsp_valid), 8'd0);
      check("abort_acc_hold", acc, 8'h00);
    end

    for (int i = 0; i < 12; i++)
      do_op(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 2)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port req_valid  input  1  operation request valid.
REQ-004 SHALL have port req_ready  output  1  block can accept a request.
REQ-005 SHALL have port req_op  input  3  opcode: 0 LOAD, 1 ADD, 2 ADC, 3 SUB, 4 SBB, 5 INC, 6 DEC, 7 CLR.
REQ-006 SHALL have port req_operand  input  8  B operand, or LOAD value.
REQ-007 SHALL have ports au_a  output  8, au_b  output  8, au_cin  output  1, au_s  output  2  drive the downstream 8-bit arithmetic unit.
REQ-008 SHALL have ports au_data  input  8, au_cout  input  1, au_ovf  input  1  arithmetic unit results (combinational in au_* outputs).
REQ-009 SHALL have port rsp_valid  output  1  result valid.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have ports acc  output  8, carry  output  1, ovf  output  1, zero  output  1  registered accumulator and flags.

Function
REQ-012 SHALL implement states IDLE, EXEC, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-013 IDLE: on req_valid&req_ready at edge N, latch req_op/req_operand into op_q/opd_q and go to EXEC.
REQ-014 EXEC (one cycle): drive au_a=acc, au_b=opd_q, au_s/au_cin per REQ-015; at edge N+1 write acc/flags and go to RESP; rsp_valid high from edge N+1.
REQ-015 Mapping (au_s, au_cin): ADD (1,0); ADC (1,carry); SUB (2,1); SBB (2,carry); INC (0,1); DEC (3,0); LOAD and CLR (0,0), AU result ignored.
REQ-016 Arithmetic ops: acc<=au_data, carry<=au_cout, ovf<=au_ovf, zero<=(au_data==0).
REQ-017 LOAD: acc<=opd_q, carry and ovf unchanged, zero<=(opd_q==0); CLR: acc<=0, carry<=0, ovf<=0, zero<=1.
REQ-018 RESP: hold all outputs stable; on rsp_ready go to IDLE at that edge; rsp_valid&rsp_ready and a new request cannot coincide (req_ready=0 in RESP).
REQ-019 Outside EXEC: au_a=acc, au_b=0, au_s=0, au_cin=0.
REQ-020 req_op/req_operand changes outside the accept edge SHALL have no effect; request-to-response latency fixed at 1 cycle, throughput one op per 3 cycles when rsp_ready is held high.
REQ-021 8-bit wrap-around is inherited from the AU (0xFF INC -> 0x00, carry=1; 0x00 DEC -> 0xFF, carry=0).

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, acc=0x00, carry=0, ovf=0, zero=1, op_q=0, opd_q=0, req_ready=1 once released, rsp_valid=0.
REQ-023 Reset asserted in EXEC or RESP SHALL abort the operation with no acc/flag update and no response.

Configuration
REQ-024 Macro ALU_SEQ_SAT_EN: when defined, an arithmetic op with au_ovf=1 SHALL write acc=0x7F if acc[7]==0 before the op, else 0x80, with ovf<=1, carry<=au_cout, zero<=0.
REQ-025 Without ALU_SEQ_SAT_EN, acc<=au_data unconditionally (REQ-016); port list identical in both builds.

Verification
REQ-026 Reset -> acc=0x00, zero=1, carry=0, req_ready=1, rsp_valid=0.
REQ-027 LOAD 0x3C, then ADD 0x05 with ideal AU -> acc=0x41, carry=0, zero=0; au_s=1 and au_cin=0 observed in EXEC; rsp_valid exactly one cycle after accept.
REQ-028 LOAD 0xFF, INC -> acc=0x00, carry=1, zero=1; then ADC 0x00 -> acc=0x01 (au_cin=1 in EXEC).
REQ-029 LOAD 0x10, SUB 0x10 -> acc=0x00, carry=1, zero=1; DEC -> acc=0xFF, carry=0.
REQ-030 rsp_ready held low 5 cycles -> rsp_valid and acc stable, req_ready=0, req_valid pulses ignored; rsp_ready=1 -> IDLE next cycle.
REQ-031 rst_n low during EXEC of ADD 0x01 on acc=0x20 -> acc=0x00, no rsp_valid; with ALU_SEQ_SAT_EN, forced au_ovf=1 on acc=0x70 ADD -> acc=0x7F, ovf=1.
